weight_tile_sched: RTL and testbench

Tile scheduler for the weight path of the convolution accelerator. It walks the (tile_base_m, tile_base_n) weight-tile space of one layer and issues one load per tile to the weight loader and zero-fill filter. It tracks weight-buffer occupancy and hands each filled buffer to the compute engine, overlapping the next load with the current compute when ping-pong buffering is compiled in.

---
 rtl/weight_tile_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_weight_tile_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_tile_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// weight_tile_sched : walks the weight-tile space of one layer, issues one load
// per tile and hands filled buffers to compute. Option: WEIGHT_SCHED_PINGPONG_EN
// Rev 1.0
// ----------------------------------------------------------------------------
module weight_tile_sched #(
  parameter int CW = 16,
  parameter int N  = 32,
  parameter int M  = 32,
  parameter int Tn = 16,
  parameter int Tm = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          load_start,
  output logic [CW-1:0] tile_base_m,
  output logic [CW-1:0] tile_base_n,
  output logic          load_buf,
  input  logic          load_done,
  output logic          comp_start,
  output logic          comp_buf,
  output logic          comp_last,
  input  logic          comp_done
);

`ifdef WEIGHT_SCHED_PINGPONG_EN
  localparam bit PINGPONG = 1'b1;
`else
  localparam bit PINGPONG = 1'b0;
`endif

  localparam int            TILES   = ((M + Tm - 1) / Tm) * ((N + Tn - 1) / Tn);
  localparam logic [CW-1:0] C_TILES = CW'(TILES);
  localparam logic [CW-1:0] C_LAST  = CW'(TILES - 1);
  localparam logic [CW-1:0] C_N     = CW'(N);
  localparam logic [CW-1:0] C_TN    = CW'(Tn);
  localparam logic [CW-1:0] C_TM    = CW'(Tm);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [1:0]    full_q, full_d;
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic          loading_q, loading_d;
  logic          computing_q, computing_d;
  logic [CW-1:0] ld_cnt_q, ld_cnt_d;
  logic [CW-1:0] cp_cnt_q, cp_cnt_d;
  logic [CW-1:0] base_m_q, base_m_d;
  logic [CW-1:0] base_n_q, base_n_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load_start_q, load_start_d;
  logic          load_buf_q, load_buf_d;
  logic          comp_start_q, comp_start_d;
  logic          comp_buf_q, comp_buf_d;
  logic          comp_last_q, comp_last_d;

  logic          w_run;
  logic          w_accept;
  logic          w_ld_ack;
  logic          w_cp_ack;
  logic          w_pass_end;
  logic [CW-1:0] w_n_step;

  assign w_run      = (state_q == S_RUN);
  // a start landing on the done pulse is dropped so the pass is not re-entered
  assign w_accept   = (state_q == S_IDLE) && start && !done_q;
  assign w_ld_ack   = w_run && load_done && loading_q;
  assign w_cp_ack   = w_run && comp_done && computing_q;
  assign w_pass_end = w_cp_ack && (cp_cnt_q == C_LAST);
  assign w_n_step   = base_n_q + C_TN;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept)   state_d = S_RUN;
      S_RUN:   if (w_pass_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // output / datapath next values
  always_comb begin
    full_d       = full_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    loading_d    = loading_q;
    computing_d  = computing_q;
    ld_cnt_d     = ld_cnt_q;
    cp_cnt_d     = cp_cnt_q;
    base_m_d     = base_m_q;
    base_n_d     = base_n_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    load_start_d = 1'b0;
    load_buf_d   = load_buf_q;
    comp_start_d = 1'b0;
    comp_buf_d   = comp_buf_q;
    comp_last_d  = 1'b0;

    if (w_accept) begin
      // first load is issued straight from the accepting edge
      full_d       = 2'b00;
      wr_d         = 1'b0;
      rd_d         = 1'b0;
      computing_d  = 1'b0;
      ld_cnt_d     = '0;
      cp_cnt_d     = '0;
      base_m_d     = '0;
      base_n_d     = '0;
      busy_d       = 1'b1;
      load_start_d = 1'b1;
      load_buf_d   = 1'b0;
      loading_d    = 1'b1;
      comp_buf_d   = 1'b0;
    end else if (w_run) begin
      if (w_ld_ack) begin
        full_d[wr_q] = 1'b1;
        wr_d         = PINGPONG ? ~wr_q : 1'b0;
        loading_d    = 1'b0;
        ld_cnt_d     = ld_cnt_q + C_ONE;
        if (w_n_step >= C_N) begin
          base_n_d = '0;
          base_m_d = base_m_q + C_TM;
        end else begin
          base_n_d = w_n_step;
        end
      end

      // load and compute acknowledges always target different buffers
      if (w_cp_ack) begin
        full_d[rd_q] = 1'b0;
        rd_d         = PINGPONG ? ~rd_q : 1'b0;
        computing_d  = 1'b0;
        cp_cnt_d     = cp_cnt_q + C_ONE;
        if (w_pass_end) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end

      if (!loading_q && (ld_cnt_q < C_TILES) && !full_q[wr_q]) begin
        load_start_d = 1'b1;
        load_buf_d   = wr_q;
        loading_d    = 1'b1;
      end

      if (!computing_q && full_q[rd_q]) begin
        comp_start_d = 1'b1;
        comp_buf_d   = rd_q;
        comp_last_d  = (cp_cnt_q == C_LAST);
        computing_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q       <= 2'b00;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      loading_q    <= 1'b0;
      computing_q  <= 1'b0;
      ld_cnt_q     <= '0;
      cp_cnt_q     <= '0;
      base_m_q     <= '0;
      base_n_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_start_q <= 1'b0;
      load_buf_q   <= 1'b0;
      comp_start_q <= 1'b0;
      comp_buf_q   <= 1'b0;
      comp_last_q  <= 1'b0;
    end else begin
      full_q       <= full_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      loading_q    <= loading_d;
      computing_q  <= computing_d;
      ld_cnt_q     <= ld_cnt_d;
      cp_cnt_q     <= cp_cnt_d;
      base_m_q     <= base_m_d;
      base_n_q     <= base_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      load_start_q <= load_start_d;
      load_buf_q   <= load_buf_d;
      comp_start_q <= comp_start_d;
      comp_buf_q   <= comp_buf_d;
      comp_last_q  <= comp_last_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign load_start  = load_start_q;
  assign tile_base_m = base_m_q;
  assign tile_base_n = base_n_q;
  assign load_buf    = load_buf_q;
  assign comp_start  = comp_start_q;
  assign comp_buf    = comp_buf_q;
  assign comp_last   = comp_last_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_tile_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_weight_tile_sched : directed passes over a 32x32 and a 40x20 layer.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_weight_tile_sched;

`ifdef WEIGHT_SCHED_PINGPONG_EN
  localparam int EXP_PRE = 2;
`else
  localparam int EXP_PRE = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start = 1'b0;
  logic load_done = 1'b0;
  logic comp_done = 1'b0;
  logic sel = 1'b0;  // 0 drives the 32x32 instance, 1 the 40x20 instance

  wire        a_busy, a_done, a_ls, a_lb, a_cs, a_cb, a_cl;
  wire [15:0] a_bm, a_bn;
  wire        b_busy, b_done, b_ls, b_lb, b_cs, b_cb, b_cl;
  wire [15:0] b_bm, b_bn;

  weight_tile_sched #(.CW(16), .N(32), .M(32), .Tn(16), .Tm(16)) u_dut_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .busy(a_busy), .done(a_done),
    .load_start(a_ls), .tile_base_m(a_bm), .tile_base_n(a_bn), .load_buf(a_lb),
    .load_done(load_done & ~sel), .comp_start(a_cs), .comp_buf(a_cb),
    .comp_last(a_cl), .comp_done(comp_done & ~sel)
  );

  weight_tile_sched #(.CW(16), .N(20), .M(40), .Tn(16), .Tm(16)) u_dut_b (
    .clk(clk), .rst(rst), .start(start & sel), .busy(b_busy), .done(b_done),
    .load_start(b_ls), .tile_base_m(b_bm), .tile_base_n(b_bn), .load_buf(b_lb),
    .load_done(load_done & sel), .comp_start(b_cs), .comp_buf(b_cb),
    .comp_last(b_cl), .comp_done(comp_done & sel)
  );

  wire        o_busy = sel ? b_busy : a_busy;
  wire        o_done = sel ? b_done : a_done;
  wire        o_ls   = sel ? b_ls   : a_ls;
  wire        o_lb   = sel ? b_lb   : a_lb;
  wire        o_cs   = sel ? b_cs   : a_cs;
  wire        o_cb   = sel ? b_cb   : a_cb;
  wire        o_cl   = sel ? b_cl   : a_cl;
  wire [15:0] o_bm   = sel ? b_bm   : a_bm;
  wire [15:0] o_bn   = sel ? b_bn   : a_bn;

  int checks = 0;
  int errors = 0;

  int exp_am [6] = '{0, 0, 16, 16, 0, 0};
  int exp_an [6] = '{0, 16, 0, 16, 0, 0};
  int exp_bm [6] = '{0, 0, 16, 16, 32, 32};
  int exp_bn [6] = '{0, 16, 0, 16, 0, 16};

  int   n_ld, n_cp, n_ldd, n_cpd, n_done, n_both, t_done;
  int   t_ls [16];
  int   t_cs [16];
  int   t_ld [16];
  int   t_cd [16];
  int   r_m  [16];
  int   r_n  [16];
  logic r_lb [16];
  logic r_cb [16];
  logic r_cl [16];
  logic busy_c2, ls_c2, busy_at_done, sod_busy, sod_ls;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Acts as loader and compute engine for one pass on the selected instance.
  task automatic run_pass(input int lat_ld, input int lat_cp, input int hold,
                          input int abort_ld, input bit start_on_done);
    int cyc, ldt, cpt, post, ab;
    bit fin;
    cyc = 0; ldt = -1; cpt = -1; post = -1; ab = 0; fin = 1'b0;
    n_ld = 0; n_cp = 0; n_ldd = 0; n_cpd = 0; n_done = 0; n_both = 0; t_done = -1;
    busy_c2 = 1'b0; ls_c2 = 1'b0; busy_at_done = 1'b1; sod_busy = 1'b1; sod_ls = 1'b1;
    for (int i = 0; i < 16; i++) begin
      t_ls[i] = -1; t_cs[i] = -1; t_ld[i] = -1; t_cd[i] = -1;
      r_m[i] = -1; r_n[i] = -1; r_lb[i] = 1'bx; r_cb[i] = 1'bx; r_cl[i] = 1'bx;
    end
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start     = (cyc == 1);
      load_done = 1'b0;
      comp_done = 1'b0;
      rst       = 1'b0;
      if (cyc == 2) begin
        busy_c2 = o_busy;
        ls_c2   = o_ls;
      end
      if (o_ls) begin
        if (n_ld < 16) begin
          t_ls[n_ld] = cyc; r_m[n_ld] = int'(o_bm); r_n[n_ld] = int'(o_bn); r_lb[n_ld] = o_lb;
        end
        n_ld++;
        ldt = lat_ld;
      end else if (ldt > 0) begin
        ldt--;
      end
      if (ldt == 0) begin
        load_done = 1'b1;
        ldt = -1;
        if (n_ldd < 16) t_ld[n_ldd] = cyc;
        n_ldd++;
      end
      if (o_cs) begin
        if (n_cp < 16) begin
          t_cs[n_cp] = cyc; r_cb[n_cp] = o_cb; r_cl[n_cp] = o_cl;
        end
        n_cp++;
        cpt = lat_cp;
      end else if (cpt > 0) begin
        cpt--;
      end
      if (cpt == 0 && cyc >= hold) begin
        comp_done = 1'b1;
        cpt = -1;
        if (n_cpd < 16) t_cd[n_cpd] = cyc;
        n_cpd++;
      end
      if (load_done && comp_done) n_both++;
      if (post >= 0) begin
        if (post == 0) begin
          sod_busy = o_busy;
          sod_ls   = o_ls;
        end
        post++;
        if (post >= 6) fin = 1'b1;
      end
      if (o_done) begin
        n_done++;
        if (t_done < 0) begin
          t_done       = cyc;
          busy_at_done = o_busy;
          post         = 0;
          if (start_on_done) start = 1'b1;
        end
      end
      if (abort_ld > 0 && n_ld >= abort_ld) begin
        ab++;
        if (ab == 3) rst = 1'b1;
        if (ab == 4) fin = 1'b1;
      end
    end
    start = 1'b0; load_done = 1'b0; comp_done = 1'b0; rst = 1'b0;
  endtask

  task automatic check_pass(input string tag, input int nt, input bit isb);
    int viol;
    chk({tag, "_n_load"}, n_ld, nt);
    chk({tag, "_n_comp"}, n_cp, nt);
    chk({tag, "_n_done"}, n_done, 1);
    chk({tag, "_busy_after_start"}, busy_c2, 1);
    chk({tag, "_load_after_start"}, ls_c2, 1);
    chk({tag, "_comp_start_lat"}, t_cs[0], t_ld[0] + 2);
    chk({tag, "_done_lat"}, t_done, t_cd[nt-1] + 1);
    chk({tag, "_busy_at_done"}, busy_at_done, 0);
    for (int i = 0; i < nt; i++) begin
      chk($sformatf("%s_base_m%0d", tag, i), r_m[i], isb ? exp_bm[i] : exp_am[i]);
      chk($sformatf("%s_base_n%0d", tag, i), r_n[i], isb ? exp_bn[i] : exp_an[i]);
`ifdef WEIGHT_SCHED_PINGPONG_EN
      chk($sformatf("%s_load_buf%0d", tag, i), r_lb[i], i % 2);
      chk($sformatf("%s_comp_buf%0d", tag, i), r_cb[i], i % 2);
`else
      chk($sformatf("%s_load_buf%0d", tag, i), r_lb[i], 0);
      chk($sformatf("%s_comp_buf%0d", tag, i), r_cb[i], 0);
`endif
      chk($sformatf("%s_comp_last%0d", tag, i), r_cl[i], (i == nt - 1));
    end
    viol = 0;
`ifdef WEIGHT_SCHED_PINGPONG_EN
    if (!(t_ls[1] < t_cd[0])) viol++;
    chk({tag, "_overlap"}, viol, 0);
`else
    for (int i = 0; i < nt; i++) begin
      if (!(t_ls[i] < t_cs[i])) viol++;
      if (i < nt - 1 && !(t_cd[i] < t_ls[i+1])) viol++;
    end
    chk({tag, "_alternate"}, viol, 0);
`endif
  endtask

  task automatic idle_check(input string tag);
    int hits;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      load_done = (i == 2);
      comp_done = (i == 4);
      if (o_ls || o_cs || o_busy || o_done) hits++;
    end
    load_done = 1'b0;
    comp_done = 1'b0;
    chk(tag, hits, 0);
  endtask

  initial begin
    int pre;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    sel = 1'b0;
    #1;
    chk("rst_a_ctrl", {a_busy, a_done, a_ls, a_cs, a_cl, a_lb, a_cb}, 0);
    chk("rst_a_base", {a_bm, a_bn}, 0);
    sel = 1'b1;
    #1;
    chk("rst_b_ctrl", {o_busy, o_done, o_ls, o_cs, o_cl, o_lb, o_cb}, 0);
    chk("rst_b_base", {o_bm, o_bn}, 0);
    sel = 1'b0;
    rst = 1'b0;

    // 32x32 layer, 20-cycle loader and compute
    run_pass(20, 20, 0, 0, 1'b0);
    check_pass("a20", 4, 1'b0);

    // equal latencies line up load_done with comp_done when buffers overlap
    run_pass(10, 10, 0, 0, 1'b0);
    check_pass("a10", 4, 1'b0);
`ifdef WEIGHT_SCHED_PINGPONG_EN
    chk("a10_coincident_seen", (n_both > 0), 1);
`endif

    // compute held off until cycle 100
    run_pass(5, 5, 100, 0, 1'b0);
    pre = 0;
    for (int i = 0; i < 16; i++) if (t_ls[i] >= 0 && t_ls[i] < t_cd[0]) pre++;
    chk("stall_loads_before_cd", pre, EXP_PRE);
    chk("stall_resume_lat", t_ls[EXP_PRE] - t_cd[0], 2);
    check_pass("stall", 4, 1'b0);

    // 40x20 layer with a start that coincides with done
    sel = 1'b1;
    run_pass(7, 9, 0, 0, 1'b1);
    check_pass("b", 6, 1'b1);
    chk("b_start_on_done_busy", sod_busy, 0);
    chk("b_start_on_done_load", sod_ls, 0);
    idle_check("b_idle_stray");

    // reset during the second load, then a fresh pass
    sel = 1'b0;
    run_pass(8, 6, 0, 2, 1'b0);
    chk("abort_loads", n_ld, 2);
    idle_check("abort_idle");
    run_pass(20, 20, 0, 0, 1'b0);
    check_pass("restart", 4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
